// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: brings a gray-coded pointer from a foreign clock domain into
// clk. The pointer passes through a plain flop synchronizer and is decoded to
// binary. Each pointer advance is reported as a valid pulse with its step size,
// and a sticky flag records any sampled transition that changed more than one
// gray bit.
module gray_ptr_sync #(
   parameter int unsigned SIZE        = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] gray_async,
   input  logic            err_clr,
   output logic [SIZE-1:0] gray_sync,
   output logic [SIZE-1:0] bin,
   output logic            bin_valid,
   output logic [SIZE-1:0] step,
   output logic            err
);

   // Synchronizer chain, packed with the oldest sample in the top SIZE bits
   logic [SYNC_STAGES*SIZE-1:0] sync_q;
   logic [SIZE-1:0]             g_s;
   logic [SIZE-1:0]             g_bin;
   logic [SIZE-1:0]             diff;
   logic                        changed;
   logic                        multi;

   // Shift the foreign pointer through the synchronizer flops, no logic between
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[(SYNC_STAGES-1)*SIZE-1:0], gray_async};
      end
   end

   assign g_s = sync_q[SYNC_STAGES*SIZE-1 -: SIZE];

   // Gray to binary: bit i is the XOR of all gray bits at i and above
   always_comb begin
      g_bin = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         g_bin[i] = ^(g_s >> i);
      end
   end

   // Change detection; clearing the lowest set bit leaves a residue only if
   // two or more bits differ
   always_comb begin
      diff    = g_s ^ gray_sync;
      changed = |diff;
      multi   = |(diff & (diff - SIZE'(1)));
   end

   // Accept a new synchronized value, decode it and report the advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_sync <= '0;
         bin       <= '0;
         step      <= '0;
         bin_valid <= 1'b0;
      end else if (changed) begin
         gray_sync <= g_s;
         bin       <= g_bin;
         step      <= g_bin - bin;
         bin_valid <= 1'b1;
      end else begin
         bin_valid <= 1'b0;
      end
   end

   // Sticky multi-bit-change flag; a violation wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (changed && multi) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Testbench for gray_ptr_sync: directed scenarios with hand-computed values,
// then a randomized pointer walk checked every cycle against a reference model.
module tb_gray_ptr_sync;

   localparam int unsigned SIZE        = 8;
   localparam int unsigned SYNC_STAGES = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [SIZE-1:0] gray_async;
   logic            err_clr;
   logic [SIZE-1:0] gray_sync;
   logic [SIZE-1:0] bin;
   logic            bin_valid;
   logic [SIZE-1:0] step;
   logic            err;

   int checks = 0;
   int errors = 0;

   gray_ptr_sync #(
      .SIZE       (SIZE),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_async(gray_async),
      .err_clr   (err_clr),
      .gray_sync (gray_sync),
      .bin       (bin),
      .bin_valid (bin_valid),
      .step      (step),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] to_gray(input logic [SIZE-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [SIZE-1:0] to_bin(input logic [SIZE-1:0] g);
      logic [SIZE-1:0] b;
      logic            acc;
      acc = 1'b0;
      b   = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         acc  = acc ^ g[i];
         b[i] = acc;
      end
      return b;
   endfunction

   // Reference model: inputs become visible SYNC_STAGES edges after capture
   logic [SIZE-1:0] m_gs    = '0;
   logic [SIZE-1:0] m_bin   = '0;
   logic [SIZE-1:0] m_step  = '0;
   logic            m_valid = 1'b0;
   logic            m_err   = 1'b0;
   logic [SIZE-1:0] m_hist[$];

   always @(posedge clk or negedge rst_n) begin
      logic [SIZE-1:0] g;
      logic [SIZE-1:0] nb;
      if (!rst_n) begin
         m_gs = '0; m_bin = '0; m_step = '0; m_valid = 1'b0; m_err = 1'b0;
         m_hist = {};
      end else begin
         while (m_hist.size() < SYNC_STAGES) m_hist.push_front('0);
         g = m_hist.pop_front();
         m_hist.push_back(gray_async);
         if (g != m_gs) begin
            nb      = to_bin(g);
            m_step  = nb - m_bin;
            m_bin   = nb;
            m_valid = 1'b1;
            if ($countones(g ^ m_gs) > 1) m_err = 1'b1;
            else if (err_clr)             m_err = 1'b0;
            m_gs = g;
         end else begin
            m_valid = 1'b0;
            if (err_clr) m_err = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, plus wrap-walk pulse bookkeeping
   bit wrap_mode  = 1'b0;
   int wrap_count = 0;

   always @(posedge clk) begin
      #1;
      chk("gray_sync", 32'(gray_sync), 32'(m_gs));
      chk("bin",       32'(bin),       32'(m_bin));
      chk("bin_valid", 32'(bin_valid), 32'(m_valid));
      chk("step",      32'(step),      32'(m_step));
      chk("err",       32'(err),       32'(m_err));
      if (wrap_mode && bin_valid) begin
         wrap_count++;
         chk("wrap_step", 32'(step), 32'd1);
         chk("wrap_err",  32'(err),  32'd0);
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      gray_async = '0;
      err_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      gray_async = 8'h5A;
      err_clr    = 1'b0;

      // Reset holds everything at zero regardless of the input
      edges(3);
      chk("rst_gray_sync", 32'(gray_sync), 32'h0);
      chk("rst_bin",       32'(bin),       32'h0);
      chk("rst_step",      32'(step),      32'h0);
      chk("rst_valid",     32'(bin_valid), 32'h0);
      chk("rst_err",       32'(err),       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      edges(3);
      chk("first_bin",   32'(bin),       32'h6C);
      chk("first_step",  32'(step),      32'h6C);
      chk("first_valid", 32'(bin_valid), 32'h1);
      chk("first_err",   32'(err),       32'h1);

      // Latency of a single legal change from reset
      do_reset();
      @(negedge clk);
      gray_async = 8'h01;
      edges(1);
      chk("lat_e1_valid", 32'(bin_valid), 32'h0);
      edges(1);
      chk("lat_e2_valid", 32'(bin_valid), 32'h0);
      edges(1);
      chk("lat_bin",   32'(bin),       32'h1);
      chk("lat_step",  32'(step),      32'h1);
      chk("lat_valid", 32'(bin_valid), 32'h1);
      chk("lat_err",   32'(err),       32'h0);
      edges(1);
      chk("lat_e4_valid", 32'(bin_valid), 32'h0);

      // Full gray walk with wrap back to zero
      do_reset();
      @(negedge clk);
      wrap_count = 0;
      wrap_mode  = 1'b1;
      for (int v = 1; v <= 256; v++) begin
         gray_async = to_gray(SIZE'(v));
         repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      wrap_mode = 1'b0;
      chk("wrap_pulses", 32'(wrap_count), 32'd256);
      chk("wrap_bin",    32'(bin),        32'h0);
      chk("wrap_errend", 32'(err),        32'h0);

      // Multi-bit violation, then clear priority
      do_reset();
      @(negedge clk);
      gray_async = 8'h03;
      edges(3);
      chk("mb_bin",  32'(bin),  32'h2);
      chk("mb_step", 32'(step), 32'h2);
      chk("mb_err",  32'(err),  32'h1);
      @(negedge clk);
      gray_async = 8'h02;
      edges(4);
      chk("mb_sticky_bin", 32'(bin), 32'h3);
      chk("mb_sticky_err", 32'(err), 32'h1);
      @(negedge clk);
      gray_async = 8'h03;
      edges(4);
      @(negedge clk);
      gray_async = 8'h0C;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      err_clr = 1'b1;
      edges(1);
      chk("clr_prio_bin",  32'(bin),  32'h08);
      chk("clr_prio_step", 32'(step), 32'h06);
      chk("clr_prio_err",  32'(err),  32'h1);
      edges(1);
      chk("clr_alone_err", 32'(err), 32'h0);
      @(negedge clk);
      err_clr = 1'b0;

      // Asynchronous reset in the middle of operation
      gray_async = 8'h60;
      edges(3);
      chk("mid_bin", 32'(bin), 32'h40);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gray_sync", 32'(gray_sync), 32'h0);
      chk("mid_rst_bin",       32'(bin),       32'h0);
      chk("mid_rst_step",      32'(step),      32'h0);
      chk("mid_rst_valid",     32'(bin_valid), 32'h0);
      chk("mid_rst_err",       32'(err),       32'h0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      edges(3);
      chk("resume_bin",  32'(bin),  32'h40);
      chk("resume_step", 32'(step), 32'h40);
      chk("resume_err",  32'(err),  32'h1);

      // Randomized walk: mostly single-bit flips, some jumps, random clears
      for (int c = 0; c < 3000; c++) begin
         int unsigned r;
         @(negedge clk);
         r = $urandom_range(99);
         if (r < 55) begin
            gray_async = gray_async ^ (SIZE'(1) << $urandom_range(SIZE - 1));
         end else if (r < 62) begin
            gray_async = SIZE'($urandom);
         end
         err_clr = ($urandom_range(7) == 0);
         if ($urandom_range(599) == 0) begin
            #2;
            rst_n = 1'b0;
            @(negedge clk);
            #2;
            rst_n = 1'b1;
         end
      end
      @(negedge clk);
      err_clr = 1'b0;
      edges(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
